// File: rtl/clk_div_ctrl_if.sv
// Ratio configuration channel for clk_div_ctrl.
// Valid/ready transfer of a divide ratio plus an illegal-ratio flag.
interface clk_div_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time divide-ratio controller for the divided clock path.
// Ratios swap only at period wraps so clk_div never shows a runt.
module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    clk_div_ctrl_if.slave    cfg,
    output logic [CNT_W-1:0] cur_div,
    output logic             div_active,
    output logic             tick,
    output logic             clk_div
);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] last;
    logic             xfer;
    logic             legal;
    logic             xfer_ok;
    logic             wrap;
    logic             clk_pose;
    logic             clk_nege;
    logic             phase_odd;

    assign xfer    = cfg.cfg_valid && cfg.cfg_ready;
    assign legal   = cfg.cfg_div >= CNT_W'(2);
    assign xfer_ok = xfer && legal;
    assign last    = cur_div - CNT_W'(1);
    assign wrap    = (state != IDLE) && (cnt == last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: stop and ratio swaps are only honoured at the wrap.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (enable) state_nx = RUN;
            RUN: begin
                if (wrap) begin
                    state_nx = enable ? RUN : IDLE;
                end else if (xfer_ok) begin
                    state_nx = PEND;
                end
            end
            PEND: if (wrap) state_nx = enable ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        cfg.cfg_ready = (state != PEND);
        div_active    = (state != IDLE);
    end

    // Ratio in effect and waiting ratio; a RUN transfer on the wrap applies at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_div  <= CNT_W'(DEFAULT_DIV);
            pend_div <= '0;
        end else begin
            if (xfer_ok) pend_div <= cfg.cfg_div;
            if (state == IDLE) begin
                if (xfer_ok) cur_div <= cfg.cfg_div;
            end else if (wrap) begin
                if (state == PEND) begin
                    cur_div <= pend_div;
                end else if (xfer_ok) begin
                    cur_div <= cfg.cfg_div;
                end
            end
        end
    end

    // Period counter, held at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == IDLE || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Illegal ratio flag, one cycle after the offending transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_err <= xfer && !legal;
        end
    end

    // Rising-edge phase, period tick and parity, all one cycle behind cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_pose  <= 1'b0;
            tick      <= 1'b0;
            phase_odd <= 1'b0;
        end else begin
            clk_pose  <= div_active && (cnt < (cur_div >> 1));
            tick      <= div_active && (cnt == '0);
            phase_odd <= cur_div[0];
        end
    end

    // Half-cycle extension of the high phase for odd ratios.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_nege <= 1'b0;
        end else begin
            clk_nege <= clk_pose;
        end
    end

    assign clk_div = phase_odd ? (clk_pose | clk_nege) : clk_pose;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with queued expectations.
// Monitors pop ticks, high pulses and error flags as the DUT shows them.
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] cur_div;
    logic       div_active;
    logic       tick;
    logic       clk_div;

    clk_div_ctrl_if #(.CNT_W(8)) cfg_if ();

    clk_div_ctrl #(
        .CNT_W      (8),
        .DEFAULT_DIV(5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cfg       (cfg_if),
        .cur_div   (cur_div),
        .div_active(div_active),
        .tick      (tick),
        .clk_div   (clk_div)
    );

    always #10 clk = ~clk;

    typedef struct {
        int div;
        int gap;
    } tick_exp_t;

    tick_exp_t tick_q[$];
    int        high_q[$];
    int        err_q[$];
    tick_exp_t te;
    int        n_vec = 0;
    int        n_bad = 0;
    int        cyc = 0;
    int        last_tick = -1;
    int        hi_run = 0;
    logic      prev_cd = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    task automatic push(input int d, input int g);
        tick_q.push_back('{div: d, gap: g});
        high_q.push_back(d);
    endtask

    task automatic wait_tick(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = tick;
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s: got no tick in 40 cycles, want tick", name);
        end
    endtask

    // Tick and error monitor, sampled mid low phase of clk.
    always @(negedge clk) begin
        #5;
        cyc++;
        if (!rst_n) begin
            last_tick = -1;
        end else begin
            if (tick) begin
                if (tick_q.size() == 0) begin
                    fail("tick_extra");
                end else begin
                    te = tick_q.pop_front();
                    chk("tick_div", int'(cur_div), te.div);
                    if (te.gap != 0) chk("tick_gap", cyc - last_tick, te.gap);
                end
                last_tick = cyc;
            end
            if (cfg_if.cfg_err) begin
                if (err_q.size() == 0) fail("err_extra");
                else chk("err_cur_div", int'(cur_div), err_q.pop_front());
            end
        end
    end

    // High-pulse monitor in half-cycle units: N half-cycles for any N.
    always @(posedge clk or negedge clk) begin
        #5;
        if (!rst_n) begin
            hi_run  = 0;
            prev_cd = 1'b0;
        end else begin
            if (clk_div) begin
                hi_run++;
            end else if (prev_cd) begin
                if (high_q.size() == 0) fail("high_extra");
                else chk("high_halves", hi_run, high_q.pop_front());
                hi_run = 0;
            end
            prev_cd = clk_div;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        enable = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div = 8'd0;
        #2 rst_n = 1'b0;
        #23;
        chk("rst_cur_div", int'(cur_div), 5);
        chk("rst_ready", int'(cfg_if.cfg_ready), 1);
        chk("rst_err", int'(cfg_if.cfg_err), 0);
        chk("rst_active", int'(div_active), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_clk_div", int'(clk_div), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // N=5 run, stop requested at cnt=1 of the third period
        push(5, 0);
        push(5, 5);
        push(5, 5);
        @(negedge clk);
        enable = 1'b1;
        repeat (3) wait_tick("a_tick");
        enable = 1'b0;
        chk("a_still_active", int'(div_active), 1);
        repeat (12) @(negedge clk);
        chk("a_idle", int'(div_active), 0);
        chk("a_clk_low", int'(clk_div), 0);
        chk("a_cur_div", int'(cur_div), 5);

        // Load N=4 in idle, then swap to 5 and 8 mid-period, then illegal ratios
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd4;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("b_idle_load", int'(cur_div), 4);
        push(4, 0);
        push(5, 4);
        push(5, 5);
        push(8, 5);
        push(8, 8);
        push(8, 8);
        enable = 1'b1;
        wait_tick("b_tick4");
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd5;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("b_pend_ready", int'(cfg_if.cfg_ready), 0);
        chk("b_pend_div", int'(cur_div), 4);
        wait_tick("b_tick5a");
        chk("b_new_div5", int'(cur_div), 5);
        chk("b_ready_back", int'(cfg_if.cfg_ready), 1);
        wait_tick("b_tick5b");
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd8;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("b_pend8_ready", int'(cfg_if.cfg_ready), 0);
        chk("b_pend8_div", int'(cur_div), 5);
        wait_tick("b_tick8a");
        chk("b_new_div8", int'(cur_div), 8);
        chk("b_ready8", int'(cfg_if.cfg_ready), 1);
        err_q.push_back(8);
        err_q.push_back(8);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd1;
        @(negedge clk);
        chk("b_err1", int'(cfg_if.cfg_err), 1);
        cfg_if.cfg_div = 8'd0;
        @(negedge clk);
        chk("b_err0", int'(cfg_if.cfg_err), 1);
        cfg_if.cfg_valid = 1'b0;
        chk("b_err_keep", int'(cur_div), 8);
        chk("b_err_ready", int'(cfg_if.cfg_ready), 1);
        wait_tick("b_tick8b");
        wait_tick("b_tick8c");
        enable = 1'b0;
        repeat (16) @(negedge clk);
        chk("b_idle", int'(div_active), 0);
        chk("b_clk_low", int'(clk_div), 0);

        // Reset in the middle of a high phase
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd4;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("c_idle_load", int'(cur_div), 4);
        tick_q.push_back('{div: 4, gap: 0});
        enable = 1'b1;
        wait_tick("c_tick");
        chk("c_high", int'(clk_div), 1);
        #7 rst_n = 1'b0;
        #1;
        chk("c_rst_clk", int'(clk_div), 0);
        chk("c_rst_tick", int'(tick), 0);
        chk("c_rst_active", int'(div_active), 0);
        chk("c_rst_div", int'(cur_div), 5);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("c_post_div", int'(cur_div), 5);
        chk("c_post_ready", int'(cfg_if.cfg_ready), 1);
        chk("c_post_active", int'(div_active), 0);
        repeat (4) @(negedge clk);

        chk("left_ticks", tick_q.size(), 0);
        chk("left_highs", high_q.size(), 0);
        chk("left_errs", err_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
